// File: rtl/t5_pkg.sv
// Shared constants for the t5 instruction-fetch responder: FSM state encoding and width defaults.
package t5_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int IBUFN_DEF = 4;

   localparam logic [0:0] S_REQ = 1'b0;
   localparam logic [0:0] S_VLD = 1'b1;

endpackage

// File: rtl/t5_ibuf.sv
// Direct-mapped fetch buffer: combinational lookup on the current word address, fill on memory ack.
// Only instantiated when T5_IBUF_EN is defined.
module t5_ibuf
   import t5_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int IBUFN = IBUFN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inv,
   input  logic [XLEN-3:0] adr,
   output logic            hit,
   output logic [XLEN-1:0] hit_dat,
   input  logic            fill_en,
   input  logic [XLEN-1:0] fill_dat
);

   localparam int IDXW = $clog2(IBUFN);
   localparam int TAGW = XLEN - 2 - IDXW;

   logic [IBUFN-1:0] valid_q;
   logic [TAGW-1:0]  tag_q [IBUFN];
   logic [XLEN-1:0]  dat_q [IBUFN];

   logic [IDXW-1:0]  idx;
   logic [TAGW-1:0]  tag;

   assign idx = adr[IDXW-1:0];
   assign tag = adr[XLEN-3:IDXW];

   // An invalidate in flight must not return data that is about to be discarded.
   assign hit     = valid_q[idx] && (tag_q[idx] == tag) && !inv;
   assign hit_dat = dat_q[idx];

   always_ff @(posedge clk) begin
      if (rst || inv) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en && !inv) begin
         tag_q[idx] <= tag;
         dat_q[idx] <= fill_dat;
      end
   end

endmodule

// File: rtl/t5_ifetch_rsp.sv
// Instruction-fetch responder: one outstanding strobe/ack read per core fetch, registered idat,
// one-cycle ena pulse. Optional fetch buffer enabled by defining T5_IBUF_EN.
//
// state | meaning
// S_REQ | fetch pending: strobe memory (or look up buffer) for iadr, core stalled
// S_VLD | idat holds the fetched word, ena pulses for this single cycle
module t5_ifetch_rsp
   import t5_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int IBUFN = IBUFN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:2] iadr,
   output logic [XLEN-1:0] idat,
   output logic            ena,
   input  logic            ibuf_inv,
   output logic [XLEN-1:2] mem_adr,
   output logic            mem_stb,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_dat
);

   logic [0:0]      state;
   logic            hit;
   logic [XLEN-1:0] hit_dat;
   logic            acc;

`ifdef T5_IBUF_EN
   t5_ibuf #(
      .XLEN  (XLEN),
      .IBUFN (IBUFN)
   ) u_ibuf (
      .clk      (clk),
      .rst      (rst),
      .inv      (ibuf_inv),
      .adr      (iadr),
      .hit      (hit),
      .hit_dat  (hit_dat),
      .fill_en  (acc),
      .fill_dat (mem_dat)
   );
`else
   logic unused_ibuf;
   assign unused_ibuf = ibuf_inv & (IBUFN > 0);
   assign hit         = 1'b0;
   assign hit_dat     = '0;
`endif

   // Strobe drops combinationally in the reset cycle so an in-flight read is cancelled at once.
   assign mem_stb = !rst && (state == S_REQ) && !hit;
   assign mem_adr = mem_stb ? iadr : '0;
   assign ena     = !rst && (state == S_VLD);
   assign acc     = mem_stb && mem_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_REQ;
         idat  <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (hit) begin
                  idat  <= hit_dat;
                  state <= S_VLD;
               end else if (acc) begin
                  idat  <= mem_dat;
                  state <= S_VLD;
               end
            end
            S_VLD:   state <= S_REQ;
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_t5_ifetch_rsp.sv
// Directed bench for t5_ifetch_rsp; buffer scenarios run only when T5_IBUF_EN is defined.
module tb_t5_ifetch_rsp;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:2] iadr;
   logic [31:0] idat;
   logic        ena;
   logic        ibuf_inv;
   logic [31:2] mem_adr;
   logic        mem_stb;
   logic        mem_ack;
   logic [31:0] mem_dat;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   t5_ifetch_rsp dut (
      .clk      (clk),
      .rst      (rst),
      .iadr     (iadr),
      .idat     (idat),
      .ena      (ena),
      .ibuf_inv (ibuf_inv),
      .mem_adr  (mem_adr),
      .mem_stb  (mem_stb),
      .mem_ack  (mem_ack),
      .mem_dat  (mem_dat)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge, apply inputs, let combinational outputs settle.
   task automatic drive(input logic r, input logic [31:2] a, input logic ack,
                        input logic [31:0] d, input logic inv);
      @(negedge clk);
      rst = r; iadr = a; mem_ack = ack; mem_dat = d; ibuf_inv = inv;
      #1;
   endtask

   initial begin
      rst = 1'b1; iadr = '0; mem_ack = 1'b0; mem_dat = '0; ibuf_inv = 1'b0;

      // reset state
      drive(1'b1, 30'h0, 1'b0, 32'h0, 1'b0);
      chk("rst_stb", {31'b0, mem_stb}, 32'd0);
      chk("rst_ena", {31'b0, ena}, 32'd0);
      chk("rst_adr", {2'b0, mem_adr}, 32'd0);
      chk("rst_idat", idat, 32'd0);

      // 1: ack in the strobe cycle, ena on cycle 2
      drive(1'b0, 30'h0, 1'b1, 32'h00000013, 1'b0);
      chk("t1_stb", {31'b0, mem_stb}, 32'd1);
      chk("t1_ena0", {31'b0, ena}, 32'd0);
      drive(1'b0, 30'h0, 1'b0, 32'h0, 1'b0);
      chk("t1_ena", {31'b0, ena}, 32'd1);
      chk("t1_idat", idat, 32'h00000013);
      chk("t1_stb_vld", {31'b0, mem_stb}, 32'd0);

      // 2: slow memory, ack after 5 strobe cycles
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 30'h40, 1'b0, 32'h0, 1'b0);
         chk("t2_stb", {31'b0, mem_stb}, 32'd1);
         chk("t2_adr", {2'b0, mem_adr}, 32'h40);
         chk("t2_ena", {31'b0, ena}, 32'd0);
      end
      drive(1'b0, 30'h40, 1'b1, 32'hAAAA5555, 1'b0);
      chk("t2_stb_ack", {31'b0, mem_stb}, 32'd1);
      chk("t2_ena_ack", {31'b0, ena}, 32'd0);

      // 3: spurious ack during S_VLD
      drive(1'b0, 30'h40, 1'b1, 32'hDEADBEEF, 1'b0);
      chk("t3_ena", {31'b0, ena}, 32'd1);
      chk("t3_idat", idat, 32'hAAAA5555);
      chk("t3_stb", {31'b0, mem_stb}, 32'd0);
      drive(1'b0, 30'h44, 1'b0, 32'h0, 1'b0);
      chk("t3_ena_after", {31'b0, ena}, 32'd0);
      chk("t3_idat_after", idat, 32'hAAAA5555);
      chk("t3_next_stb", {31'b0, mem_stb}, 32'd1);
      chk("t3_next_adr", {2'b0, mem_adr}, 32'h44);

      // 4: reset during an unacked fetch, ack in the reset cycle ignored
      drive(1'b1, 30'h44, 1'b1, 32'h12345678, 1'b0);
      chk("t4_stb_rst", {31'b0, mem_stb}, 32'd0);
      chk("t4_ena_rst", {31'b0, ena}, 32'd0);
      drive(1'b0, 30'h44, 1'b0, 32'h0, 1'b0);
      chk("t4_idat", idat, 32'd0);
      chk("t4_ena", {31'b0, ena}, 32'd0);
      chk("t4_stb_again", {31'b0, mem_stb}, 32'd1);
      chk("t4_adr_again", {2'b0, mem_adr}, 32'h44);
      drive(1'b0, 30'h44, 1'b1, 32'h00100073, 1'b0);
      drive(1'b0, 30'h44, 1'b0, 32'h0, 1'b0);
      chk("t4_ena_done", {31'b0, ena}, 32'd1);
      chk("t4_idat_done", idat, 32'h00100073);

`ifdef T5_IBUF_EN
      // 5: hit on repeat fetch, conflicting tag misses
      drive(1'b0, 30'h10, 1'b1, 32'h11111111, 1'b0);
      chk("t5_miss_stb", {31'b0, mem_stb}, 32'd1);
      drive(1'b0, 30'h10, 1'b0, 32'h0, 1'b0);
      chk("t5_fill_idat", idat, 32'h11111111);
      drive(1'b0, 30'h10, 1'b0, 32'h0, 1'b0);
      chk("t5_hit_stb", {31'b0, mem_stb}, 32'd0);
      chk("t5_hit_ena0", {31'b0, ena}, 32'd0);
      drive(1'b0, 30'h10, 1'b0, 32'h0, 1'b0);
      chk("t5_hit_ena", {31'b0, ena}, 32'd1);
      chk("t5_hit_idat", idat, 32'h11111111);
      drive(1'b0, 30'h14, 1'b1, 32'h22222222, 1'b0);
      chk("t5_conf_stb", {31'b0, mem_stb}, 32'd1);
      drive(1'b0, 30'h14, 1'b0, 32'h0, 1'b0);
      chk("t5_conf_idat", idat, 32'h22222222);
      drive(1'b0, 30'h10, 1'b1, 32'h33333333, 1'b0);
      chk("t5_evict_stb", {31'b0, mem_stb}, 32'd1);
      drive(1'b0, 30'h10, 1'b0, 32'h0, 1'b0);
      chk("t5_evict_idat", idat, 32'h33333333);

      // 6: invalidate forces a miss and wins over the same-cycle fill
      drive(1'b0, 30'h10, 1'b1, 32'h44444444, 1'b1);
      chk("t6_inv_stb", {31'b0, mem_stb}, 32'd1);
      drive(1'b0, 30'h10, 1'b0, 32'h0, 1'b0);
      chk("t6_inv_idat", idat, 32'h44444444);
      drive(1'b0, 30'h10, 1'b1, 32'h55555555, 1'b0);
      chk("t6_refetch_stb", {31'b0, mem_stb}, 32'd1);
      drive(1'b0, 30'h10, 1'b0, 32'h0, 1'b0);
      chk("t6_refetch_idat", idat, 32'h55555555);
      drive(1'b0, 30'h10, 1'b0, 32'h0, 1'b0);
      chk("t6_hit_stb", {31'b0, mem_stb}, 32'd0);
      drive(1'b0, 30'h10, 1'b0, 32'h0, 1'b0);
      chk("t6_hit_idat", idat, 32'h55555555);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
